// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-mode encodings and the legality check used by the
// dmem arbiter. Build option DMEM_ARB_RR_EN is consumed by arb2_grant only.
//   MODE_*         dmem access modes (word, half/byte unsigned/signed, idle)
//   is_legal_mode  1 for the five encodings dmem understands
package dmem_pkg;

  localparam logic [2:0] MODE_W    = 3'b000;
  localparam logic [2:0] MODE_HU   = 3'b001;
  localparam logic [2:0] MODE_HS   = 3'b101;
  localparam logic [2:0] MODE_BU   = 3'b010;
  localparam logic [2:0] MODE_BS   = 3'b110;
  localparam logic [2:0] MODE_IDLE = 3'b111;

  function automatic logic is_legal_mode(input logic [2:0] mode);
    logic legal;
    case (mode)
      MODE_W, MODE_HU, MODE_HS, MODE_BU, MODE_BS: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/arb2_grant.sv
// arb2_grant: combinational two-way grant.
// Build option DMEM_ARB_RR_EN selects round-robin (rr_ptr register present);
// otherwise fixed priority m0 > m1.
//   clk     in   clock (only used for rr_ptr)
//   reset   in   synchronous active-high; forces no grant
//   i_req   in   [1:0] request per master
//   o_gnt   out  [1:0] one-hot-or-zero grant
module arb2_grant (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

`ifdef DMEM_ARB_RR_EN
  // 0 = m0 wins a tie, 1 = m1 wins a tie
  logic r_rr_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (!reset) begin
      if (i_req == 2'b11) o_gnt = r_rr_ptr ? 2'b10 : 2'b01;
      else                o_gnt = i_req;
    end
  end

  // Point at the master that did not win this cycle.
  always_ff @(posedge clk) begin
    if (reset)       r_rr_ptr <= 1'b0;
    else if (|o_gnt) r_rr_ptr <= o_gnt[0];
  end
`else
  logic w_unused_clk;
  assign w_unused_clk = clk;

  always_comb begin
    o_gnt = 2'b00;
    if (!reset) begin
      o_gnt[0] = i_req[0];
      o_gnt[1] = i_req[1] & ~i_req[0];
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master req/gnt front end for the single-port dmem.
// Grant (cycle N) -> command register (N+1 drives dmem) -> response (N+2).
// Build option DMEM_ARB_RR_EN: round-robin instead of fixed m0 > m1 priority.
//   clk, reset                synchronous active-high reset
//   mN_req/we/mode/addr/wdata master N request (held until mN_gnt)
//   mN_gnt                    combinational accept
//   mN_rvalid/rdata/err       registered one-cycle response
//   dmem_a/wd/we/mode, dmem_rd memory interface (dmem writes on negedge)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [2:0]    m0_mode,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [2:0]    m1_mode,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic [31:0]   dmem_a,
  output logic [31:0]   dmem_wd,
  output logic          dmem_we,
  output logic [2:0]    dmem_mode,
  input  logic [31:0]   dmem_rd
);

  logic [1:0]    w_gnt;
  logic          w_sel;
  logic          w_we;
  logic [2:0]    w_mode;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_wdata;
  logic          w_err;

  arb2_grant u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req ({m1_req, m0_req}),
    .o_gnt (w_gnt)
  );

  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  assign w_sel   = w_gnt[1];
  assign w_we    = w_sel ? m1_we    : m0_we;
  assign w_mode  = w_sel ? m1_mode  : m0_mode;
  assign w_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_wdata = w_sel ? m1_wdata : m0_wdata;
  assign w_err   = ~is_legal_mode(w_mode) | (w_addr >= AW'(DEPTH));

  // Command stage
  logic          r_cmd_valid;
  logic          r_cmd_id;
  logic          r_cmd_we;
  logic [2:0]    r_cmd_mode;
  logic [AW-1:0] r_cmd_addr;
  logic [31:0]   r_cmd_wdata;
  logic          r_cmd_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_mode  <= MODE_IDLE;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_valid <= |w_gnt;
      if (|w_gnt) begin
        r_cmd_id    <= w_sel;
        r_cmd_we    <= w_we;
        r_cmd_mode  <= w_mode;
        r_cmd_addr  <= w_addr;
        r_cmd_wdata <= w_wdata;
        r_cmd_err   <= w_err;
      end
    end
  end

  // dmem drive; errored commands keep the idle mode so dmem neither reads nor writes.
  always_comb begin
    dmem_a    = '0;
    dmem_wd   = '0;
    dmem_mode = MODE_IDLE;
    if (r_cmd_valid) begin
      dmem_a  = 32'(r_cmd_addr);
      dmem_wd = r_cmd_wdata;
      if (!r_cmd_err) dmem_mode = r_cmd_mode;
    end
  end

  // Gated by reset directly so a reset in the access cycle suppresses the negedge write.
  assign dmem_we = r_cmd_valid & r_cmd_we & ~r_cmd_err & ~reset;

  // Response stage
  logic [1:0]  r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= {r_cmd_valid & r_cmd_id, r_cmd_valid & ~r_cmd_id};
      r_rdata  <= (r_cmd_valid & ~r_cmd_we & ~r_cmd_err) ? dmem_rd : 32'h0;
      r_err    <= r_cmd_valid & r_cmd_err;
    end
  end

  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_rvalid[0] ? r_rdata : 32'h0;
  assign m1_rdata  = r_rvalid[1] ? r_rdata : 32'h0;
  assign m0_err    = r_rvalid[0] & r_err;
  assign m1_err    = r_rvalid[1] & r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_mode, m1_mode;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dmem_a, dmem_wd, dmem_rd;
  logic        dmem_we;
  logic [2:0]  dmem_mode;

  dmem_arbiter #(.DEPTH(32), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_mode(m0_mode), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_mode(m1_mode), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .dmem_a(dmem_a), .dmem_wd(dmem_wd), .dmem_we(dmem_we), .dmem_mode(dmem_mode),
    .dmem_rd(dmem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory device (writes on negedge, combinational read) --------------
  logic [31:0] dev_mem [32];

  function automatic logic legal(input logic [2:0] m);
    return m == 3'b000 || m == 3'b001 || m == 3'b101 || m == 3'b010 || m == 3'b110;
  endfunction

  // Load result with extension, written as plain arithmetic.
  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] m);
    logic [31:0] h, b;
    h = w % 32'h10000;
    b = w % 32'h100;
    case (m)
      3'b001:  return h;
      3'b101:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b010:  return b;
      3'b110:  return (b >= 32'h80) ? b - 32'h100 : b;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] m);
    case (m)
      3'b001, 3'b101: return (old / 32'h10000) * 32'h10000 + wd % 32'h10000;
      3'b010, 3'b110: return (old / 32'h100) * 32'h100 + wd % 32'h100;
      default:        return wd;
    endcase
  endfunction

  assign dmem_rd = (dmem_we || !legal(dmem_mode)) ? 32'hzzzz_zzzz :
                   load_val((dmem_a < 32) ? dev_mem[dmem_a[4:0]] : 32'h0, dmem_mode);

  always @(negedge clk) begin
    if (dmem_we && dmem_a < 32)
      dev_mem[dmem_a[4:0]] <= store_val(dev_mem[dmem_a[4:0]], dmem_wd, dmem_mode);
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       q[$];
  logic [31:0] ref_mem [32];
  logic        p_req [2];
  logic        p_we [2];
  logic [2:0]  p_mode [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic        pend_st;
  logic [31:0] pend_addr, pend_wd;
  logic [2:0]  pend_mode;
  int          ref_ptr;
  int          cyc;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic issue(input int id, input logic we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wd);
    p_req[id] = 1'b1; p_we[id] = we; p_mode[id] = mode; p_addr[id] = addr; p_wd[id] = wd;
  endtask

  task automatic drive();
    m0_req = p_req[0]; m0_we = p_we[0]; m0_mode = p_mode[0];
    m0_addr = p_addr[0]; m0_wdata = p_wd[0];
    m1_req = p_req[1]; m1_we = p_we[1]; m1_mode = p_mode[1];
    m1_addr = p_addr[1]; m1_wdata = p_wd[1];
  endtask

  // One clock cycle: inputs applied at posedge+1, checks at posedge+4.
  task automatic step();
    int          win;
    logic        ev [2];
    logic        e;
    logic [31:0] rd;
    drive();
    #3;
    chk("dmem_we", 32'(dmem_we), 32'(pend_st && !reset));
    if (pend_st && !reset) ref_mem[pend_addr[4:0]] =
      store_val(ref_mem[pend_addr[4:0]], pend_wd, pend_mode);
    pend_st = 1'b0;

    win = -1;
    if (!reset) begin
      if (p_req[0] && p_req[1]) begin
`ifdef DMEM_ARB_RR_EN
        win = ref_ptr;
`else
        win = 0;
`endif
      end else if (p_req[0]) win = 0;
      else if (p_req[1]) win = 1;
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(win == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(win == 1));

    for (int n = 0; n < 2; n++) ev[n] = q.size() != 0 && q[0].cyc == cyc - 2 && q[0].id == n;
    chk("m0_rvalid", 32'(m0_rvalid), 32'(ev[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(ev[1]));
    if (ev[0] || ev[1]) begin
      chk(ev[0] ? "m0_rdata" : "m1_rdata", ev[0] ? m0_rdata : m1_rdata, q[0].rdata);
      chk(ev[0] ? "m0_err" : "m1_err", 32'(ev[0] ? m0_err : m1_err), 32'(q[0].err));
      void'(q.pop_front());
    end

    if (win >= 0) begin
      e  = !legal(p_mode[win]) || p_addr[win] >= 32;
      rd = (!p_we[win] && !e) ? load_val(ref_mem[p_addr[win][4:0]], p_mode[win]) : 32'h0;
      q.push_back('{id: win, cyc: cyc, rdata: rd, err: e});
      if (p_we[win] && !e) begin
        pend_st = 1'b1; pend_addr = p_addr[win]; pend_wd = p_wd[win]; pend_mode = p_mode[win];
      end
      p_req[win] = 1'b0;
      ref_ptr = (win == 0) ? 1 : 0;
    end
    if (reset) begin
      q.delete();
      ref_ptr = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((p_req[0] || p_req[1] || q.size() != 0 || pend_st) && n < max) begin
      step();
      n++;
    end
    total++;
    assert (n < max) else begin
      bad++;
      $error("FAIL drain_timeout: got %0d cycles want < %0d", n, max);
    end
  endtask

  task automatic check_idle(input string tag);
    drive();
    #1;
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'h0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'h0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    chk({tag, "_err"}, 32'({m1_err, m0_err}), 32'h0);
    chk({tag, "_dmem_we"}, 32'(dmem_we), 32'h0);
    chk({tag, "_dmem_mode"}, 32'(dmem_mode), 32'h7);
    chk({tag, "_dmem_a"}, dmem_a, 32'h0);
    chk({tag, "_dmem_wd"}, dmem_wd, 32'h0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [2:0] mseq [3];

  initial begin
    total = 0; bad = 0; cyc = 0; ref_ptr = 0; pend_st = 1'b0;
    pend_addr = '0; pend_wd = '0; pend_mode = '0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 32'h0;
      dev_mem[i] = 32'h0;
    end
    for (int n = 0; n < 2; n++) begin
      p_req[n] = 1'b0; p_we[n] = 1'b0; p_mode[n] = 3'b0; p_addr[n] = '0; p_wd[n] = '0;
    end
    reset = 1'b1;
    drive();
    @(posedge clk);
    #1;
    // Requests while reset is high must not be granted.
    issue(0, 1'b0, 3'b000, 32'd1, 32'h0);
    issue(1, 1'b1, 3'b000, 32'd2, 32'h5);
    step();
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    check_idle("reset");
    reset = 1'b0;

    // 1: store then load word
    issue(0, 1'b1, 3'b000, 32'd5, 32'hDEAD_BEEF);
    step();
    issue(0, 1'b0, 3'b000, 32'd5, 32'h0);
    drain(20);

    // 2: signed/unsigned sub-word loads, back-to-back
    issue(1, 1'b1, 3'b000, 32'd3, 32'h0000_80F0);
    drain(20);
    mseq[0] = 3'b101; mseq[1] = 3'b110; mseq[2] = 3'b010;
    for (int k = 0; k < 3; k++) begin
      issue(1, 1'b0, mseq[k], 32'd3, 32'h0);
      step();
    end
    drain(20);

    // 3: both request for 4 cycles
    for (int k = 0; k < 4; k++) begin
      if (!p_req[0]) issue(0, 1'b0, 3'b000, 32'(k), 32'h0);
      if (!p_req[1]) issue(1, 1'b0, 3'b010, 32'(k + 8), 32'h0);
      step();
    end
    drain(20);

    // 4: out-of-range address and illegal mode stores
    issue(0, 1'b1, 3'b000, 32'd32, 32'hFFFF_FFFF);
    step();
    issue(0, 1'b1, 3'b011, 32'd5, 32'h1111_1111);
    drain(20);
    issue(0, 1'b0, 3'b000, 32'd5, 32'h0);
    drain(20);

    // 5: reset during the access cycle of a store
    issue(0, 1'b1, 3'b000, 32'd7, 32'h1234_5678);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("post_reset");
    chk("mem7_unchanged", dev_mem[7], ref_mem[7]);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_req[n] && $urandom_range(0, 2) != 0)
          issue(n, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, 35)), $urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    drain(50);
    for (int i = 0; i < 32; i++) chk("final_mem", dev_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
